// File: rtl/csr_irq_unit.sv
// ---------------------------------------------------------------------------
// csr_irq_unit
//   Machine-mode CSR file for a single-issue core. It holds mstatus, mie,
//   mtvec, mepc and mcause, exposes mip and the 64-bit mcycle/minstret
//   counters, and sequences trap entry, MRET and the WFI sleep state.
//   CSR reads are combinational and return the value from before the
//   instruction. All updates commit on the clock edge that moves the
//   instruction out of EXE.
//
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   csr_en       CSR instruction valid in EXE
//   csr_op       funct3 (RW/RS/RC and their immediate forms)
//   csr_addr     CSR address; selects csr_rdata and the write target
//   rs1_data     register source operand
//   zimm         5-bit immediate source operand
//   src_zero     rs1 index / zimm is zero (RS/RC then do not write)
//   mret, wfi    MRET / WFI valid in EXE
//   retire       one instruction retired this cycle
//   exe_pc       PC of the instruction in EXE (saved to mepc on a trap)
//   irq_in       asynchronous level-sensitive platform interrupts
//   csr_rdata    old value of csr_addr
//   trap_take    redirect to trap_pc and squash the EXE instruction
//   trap_pc      trap handler target
//   mret_pc      MRET return target (mepc)
//   wfi_stall    pipeline hold while sleeping in WFI
// ---------------------------------------------------------------------------
module csr_irq_unit #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0001_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_en,
    input  logic [2:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        rs1_data,
    input  logic [4:0]         zimm,
    input  logic               src_zero,
    input  logic               mret,
    input  logic               wfi,
    input  logic               retire,
    input  logic [31:0]        exe_pc,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [31:0]        csr_rdata,
    output logic               trap_take,
    output logic [31:0]        trap_pc,
    output logic [31:0]        mret_pc,
    output logic               wfi_stall
);

    localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
    localparam logic [11:0] ADDR_MIE        = 12'h304;
    localparam logic [11:0] ADDR_MTVEC      = 12'h305;
    localparam logic [11:0] ADDR_MEPC       = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE     = 12'h342;
    localparam logic [11:0] ADDR_MIP        = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } wfi_state_t;

    // Architectural state
    logic [NUM_IRQ-1:0] sync1_reg;
    logic [NUM_IRQ-1:0] sync2_reg;
    logic [NUM_IRQ-1:0] mie_en_reg;     // only the implemented mie bits 16+i
    logic               mstatus_mie_reg;
    logic               mstatus_mpie_reg;
    logic [31:0]        mtvec_reg;
    logic [31:0]        mepc_reg;
    logic               mcause_irq_reg;
    logic [4:0]         mcause_code_reg;
    logic [63:0]        mcycle_reg;
    logic [63:0]        minstret_reg;
    wfi_state_t         state_reg;
    wfi_state_t         state_next;

    // Derived signals
    logic [NUM_IRQ-1:0] pend;
    logic               any_pend;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_code;
    logic [31:0]        mip_word;
    logic [31:0]        mie_word;
    logic [31:0]        mtvec_base;
    logic [31:0]        src;
    logic [31:0]        wdata;
    logic               csr_wr;

    // -----------------------------------------------------------------------
    // Interrupt synchroniser and pending selection
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign mip_word = 32'(sync2_reg) << 16;
    assign mie_word = 32'(mie_en_reg) << 16;
    assign pend     = sync2_reg & mie_en_reg;
    assign any_pend = |pend;

    // Scan from the top down so the lowest pending line is the last to
    // overwrite irq_idx and therefore wins.
    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                irq_idx = 4'(i);
            end
        end
    end

    // Platform interrupt causes are 16+i, i.e. bit 4 set plus the line index.
    assign irq_code = {1'b1, irq_idx};

    // -----------------------------------------------------------------------
    // Trap / MRET targets
    // -----------------------------------------------------------------------
    assign trap_take  = mstatus_mie_reg & any_pend;
    assign mtvec_base = {mtvec_reg[31:2], 2'b00};
    assign trap_pc    = mtvec_reg[0] ? (mtvec_base + {25'b0, irq_code, 2'b00})
                                     : mtvec_base;
    assign mret_pc    = mepc_reg;

    // -----------------------------------------------------------------------
    // CSR read mux (old value)
    // -----------------------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS:   csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg,
                                         3'b0, mstatus_mie_reg, 3'b0};
            ADDR_MIE:       csr_rdata = mie_word;
            ADDR_MTVEC:     csr_rdata = mtvec_reg;
            ADDR_MEPC:      csr_rdata = mepc_reg;
            ADDR_MCAUSE:    csr_rdata = {mcause_irq_reg, 26'b0, mcause_code_reg};
            ADDR_MIP:       csr_rdata = mip_word;
            ADDR_MCYCLE:    csr_rdata = mcycle_reg[31:0];
            ADDR_MCYCLEH:   csr_rdata = mcycle_reg[63:32];
            ADDR_MINSTRET:  csr_rdata = minstret_reg[31:0];
            ADDR_MINSTRETH: csr_rdata = minstret_reg[63:32];
            default:        csr_rdata = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write data and write enable
    // -----------------------------------------------------------------------
    assign src = csr_op[2] ? {27'b0, zimm} : rs1_data;

    always_comb begin
        wdata = csr_rdata;
        case (csr_op[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = csr_rdata | src;
            2'b11:   wdata = csr_rdata & ~src;
            default: wdata = csr_rdata;
        endcase
    end

    // A taken trap squashes everything in EXE; MRET outranks a CSR write.
    // RW always writes, RS/RC only with a non-zero source.
    assign csr_wr = csr_en & ~trap_take & ~mret &
                    ((csr_op[1:0] == 2'b01) | ((csr_op[1:0] != 2'b00) & ~src_zero));

    // -----------------------------------------------------------------------
    // mstatus
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
        end else if (trap_take) begin
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_wr && csr_addr == ADDR_MSTATUS) begin
            mstatus_mie_reg  <= wdata[3];
            mstatus_mpie_reg <= wdata[7];
        end
    end

    // -----------------------------------------------------------------------
    // mepc / mcause (written by trap entry or by software)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_reg        <= '0;
            mcause_irq_reg  <= 1'b0;
            mcause_code_reg <= '0;
        end else if (trap_take) begin
            mepc_reg        <= exe_pc;
            mcause_irq_reg  <= 1'b1;
            mcause_code_reg <= irq_code;
        end else if (csr_wr) begin
            if (csr_addr == ADDR_MEPC) begin
                mepc_reg <= {wdata[31:2], 2'b00};
            end
            if (csr_addr == ADDR_MCAUSE) begin
                mcause_irq_reg  <= wdata[31];
                mcause_code_reg <= wdata[4:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // mie / mtvec (software-only)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_en_reg <= '0;
            mtvec_reg  <= MTVEC_RESET;
        end else if (csr_wr) begin
            if (csr_addr == ADDR_MIE) begin
                mie_en_reg <= wdata[16 +: NUM_IRQ];
            end
            // Reserved modes 2/3 collapse to direct.
            if (csr_addr == ADDR_MTVEC) begin
                mtvec_reg <= {wdata[31:2], 1'b0, (wdata[1:0] == 2'b01)};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counters: free-running, read-only, wrap silently
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg <= mcycle_reg + 64'd1;
            if (retire) begin
                minstret_reg <= minstret_reg + 64'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // WFI sleep FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Wake-up ignores mstatus.MIE: a masked-globally but enabled interrupt
    // still ends the sleep, it just does not trap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (wfi && !any_pend && !trap_take) state_next = SLEEP;
            SLEEP:   if (any_pend) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign wfi_stall = (state_reg == SLEEP);

endmodule

// File: tb/tb_csr_irq_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_irq_unit
//   Self-checking bench for csr_irq_unit. Each scenario task pushes the
//   expected value onto a scoreboard queue as it drives stimulus, pushes the
//   observed DUT value when it is sampled, and compares the pairs in order.
// ---------------------------------------------------------------------------
module tb_csr_irq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en = 1'b0;
    logic [2:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] rs1_data = '0;
    logic [4:0]  zimm = '0;
    logic        src_zero = 1'b0;
    logic        mret = 1'b0;
    logic        wfi = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] exe_pc = '0;
    logic [3:0]  irq_in = '0;
    logic [31:0] csr_rdata;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic [31:0] mret_pc;
    logic        wfi_stall;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ob[$];
    int          n_vec = 0;
    int          n_err = 0;

    csr_irq_unit #(
        .NUM_IRQ     (4),
        .MTVEC_RESET (32'h0001_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_en    (csr_en),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .rs1_data  (rs1_data),
        .zimm      (zimm),
        .src_zero  (src_zero),
        .mret      (mret),
        .wfi       (wfi),
        .retire    (retire),
        .exe_pc    (exe_pc),
        .irq_in    (irq_in),
        .csr_rdata (csr_rdata),
        .trap_take (trap_take),
        .trap_pc   (trap_pc),
        .mret_pc   (mret_pc),
        .wfi_stall (wfi_stall)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus / scoreboard feed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_en   = 1'b0;
        csr_op   = '0;
        rs1_data = '0;
        zimm     = '0;
        src_zero = 1'b0;
        mret     = 1'b0;
        wfi      = 1'b0;
    endtask

    task automatic drv(input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] d, input logic [4:0] z, input logic sz);
        csr_en   = 1'b1;
        csr_op   = op;
        csr_addr = a;
        rs1_data = d;
        zimm     = z;
        src_zero = sz;
    endtask

    task automatic csr_do(input logic [2:0] op, input logic [11:0] a,
                          input logic [31:0] d, input logic [4:0] z, input logic sz);
        drv(op, a, d, z, sz);
        step();
        idle();
    endtask

    task automatic exp_rd(input string nm, input logic [11:0] a, input logic [31:0] v);
        sb.push_back('{nm, v});
        csr_addr = a;
        #1;
        ob.push_back(csr_rdata);
    endtask

    task automatic exp_val(input string nm, input logic [31:0] v, input logic [31:0] o);
        sb.push_back('{nm, v});
        ob.push_back(o);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        exp_t        e;
        logic [31:0] o;
        repeat (2) @(posedge clk);
        #1;
        exp_rd("rst_mtvec",   12'h305, 32'h0001_0000);
        exp_rd("rst_mstatus", 12'h300, 32'h0000_1800);
        exp_rd("rst_mie",     12'h304, 32'h0);
        exp_rd("rst_mcause",  12'h342, 32'h0);
        exp_rd("rst_mcycle",  12'hB00, 32'h0);
        exp_val("rst_trap_take", 32'h0, {31'b0, trap_take});
        exp_val("rst_wfi_stall", 32'h0, {31'b0, wfi_stall});
        exp_val("rst_mret_pc",   32'h0, mret_pc);
        exp_val("rst_trap_pc",   32'h0001_0000, trap_pc);
        rst = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_rw();
        exp_t        e;
        logic [31:0] o;
        step();
        drv(3'b001, 12'h305, 32'h2001, 5'd0, 1'b0);
        exp_rd("rw_old_value", 12'h305, 32'h0001_0000);
        step(); idle();
        exp_rd("rw_new_value", 12'h305, 32'h2001);
        csr_do(3'b001, 12'h305, 32'h3006, 5'd0, 1'b0);
        exp_rd("mtvec_mode2_cleared", 12'h305, 32'h3004);
        csr_do(3'b001, 12'h305, 32'h2001, 5'd0, 1'b0);
        csr_do(3'b010, 12'h304, 32'h2_0000, 5'd0, 1'b0);
        irq_in = 4'b0010;
        step(); step();
        exp_val("vec_trap_pc_irq1", 32'h2044, trap_pc);
        exp_val("no_trap_mie_off", 32'h0, {31'b0, trap_take});
        exp_rd("mip_irq1", 12'h344, 32'h2_0000);
        irq_in = 4'b0000;
        csr_do(3'b001, 12'h304, 32'h0, 5'd0, 1'b0);
        step(); step();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_rs_rc();
        exp_t        e;
        logic [31:0] o;
        drv(3'b110, 12'h304, 32'h0, 5'd0, 1'b1);
        exp_rd("rsi_zero_old", 12'h304, 32'h0);
        step(); idle();
        exp_rd("rsi_zero_mie", 12'h304, 32'h0);
        csr_do(3'b010, 12'h304, 32'h3_0000, 5'd0, 1'b0);
        exp_rd("rs_mie", 12'h304, 32'h3_0000);
        csr_do(3'b011, 12'h304, 32'h1_0000, 5'd0, 1'b0);
        exp_rd("rc_mie", 12'h304, 32'h2_0000);
        csr_do(3'b011, 12'h304, 32'h2_0000, 5'd0, 1'b1);
        exp_rd("rc_src_zero_no_write", 12'h304, 32'h2_0000);
        csr_do(3'b010, 12'h304, 32'hFFFF_FFFF, 5'd0, 1'b0);
        exp_rd("rs_mie_mask", 12'h304, 32'hF_0000);
        csr_do(3'b001, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b0);
        exp_rd("mstatus_mask", 12'h300, 32'h1888);
        csr_do(3'b111, 12'h300, 32'h0, 5'd8, 1'b0);
        exp_rd("rci_mstatus", 12'h300, 32'h1880);
        drv(3'b001, 12'h7C0, 32'h1234, 5'd0, 1'b0);
        exp_rd("unknown_old", 12'h7C0, 32'h0);
        step(); idle();
        exp_rd("unknown_after", 12'h7C0, 32'h0);
        csr_do(3'b001, 12'hB02, 32'h55, 5'd0, 1'b0);
        exp_rd("minstret_write_ignored", 12'hB02, 32'h0);
        csr_do(3'b001, 12'h304, 32'h0, 5'd0, 1'b0);
        csr_do(3'b001, 12'h300, 32'h0, 5'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_trap();
        exp_t        e;
        logic [31:0] o;
        csr_do(3'b110, 12'h300, 32'h0, 5'd8, 1'b0);
        csr_do(3'b001, 12'h304, 32'h2_0000, 5'd0, 1'b0);
        exe_pc = 32'h0000_0400;
        irq_in = 4'b0010;
        step();
        exp_val("trap_sync_wait", 32'h0, {31'b0, trap_take});
        step();
        drv(3'b001, 12'h304, 32'h0, 5'd0, 1'b0);
        #1;
        exp_val("trap_take", 32'h1, {31'b0, trap_take});
        exp_val("trap_pc", 32'h2044, trap_pc);
        step(); idle();
        exp_rd("trap_mepc",    12'h341, 32'h400);
        exp_rd("trap_mcause",  12'h342, 32'h8000_0011);
        exp_rd("trap_mstatus", 12'h300, 32'h1880);
        exp_rd("trap_csr_dropped", 12'h304, 32'h2_0000);
        exp_val("trap_masked_after", 32'h0, {31'b0, trap_take});
        exp_val("trap_mret_pc", 32'h400, mret_pc);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_mret();
        exp_t        e;
        logic [31:0] o;
        irq_in = 4'b0000;
        repeat (3) step();
        drv(3'b001, 12'h341, 32'h999, 5'd0, 1'b0);
        mret = 1'b1;
        #1;
        exp_val("mret_pc", 32'h400, mret_pc);
        exp_val("mret_no_trap", 32'h0, {31'b0, trap_take});
        step(); idle();
        exp_rd("mret_mstatus", 12'h300, 32'h1888);
        exp_rd("mret_csr_dropped", 12'h341, 32'h400);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    // Two enabled lines at once plus a same-cycle MRET: the lowest line must
    // win and the trap must override the MRET.
    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] o;
        csr_do(3'b001, 12'h304, 32'hA_0000, 5'd0, 1'b0);
        exe_pc = 32'h0000_0500;
        irq_in = 4'b1010;
        step(); step();
        mret = 1'b1;
        #1;
        exp_val("b2b_trap_take", 32'h1, {31'b0, trap_take});
        exp_val("b2b_lowest_pc", 32'h2044, trap_pc);
        step(); idle();
        exp_rd("b2b_mstatus", 12'h300, 32'h1880);
        exp_rd("b2b_mepc",    12'h341, 32'h500);
        exp_rd("b2b_mcause",  12'h342, 32'h8000_0011);
        irq_in = 4'b0000;
        csr_do(3'b001, 12'h300, 32'h0, 5'd0, 1'b0);
        step(); step();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_wfi();
        exp_t        e;
        logic [31:0] o;
        csr_do(3'b001, 12'h304, 32'h1_0000, 5'd0, 1'b0);
        wfi = 1'b1;
        #1;
        exp_val("wfi_no_trap", 32'h0, {31'b0, trap_take});
        step();
        wfi = 1'b0;
        irq_in = 4'b0001;
        #1;
        exp_val("wfi_sleep", 32'h1, {31'b0, wfi_stall});
        step();
        exp_val("wfi_sleep_sync1", 32'h1, {31'b0, wfi_stall});
        step();
        exp_val("wfi_sleep_sync2", 32'h1, {31'b0, wfi_stall});
        exp_val("wfi_wake_no_trap", 32'h0, {31'b0, trap_take});
        step();
        exp_val("wfi_woken", 32'h0, {31'b0, wfi_stall});
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        #1;
        exp_val("wfi_pending_nop", 32'h0, {31'b0, wfi_stall});
        irq_in = 4'b0000;
        step(); step();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_counters();
        exp_t        e;
        logic [31:0] o;
        retire = 1'b1;
        repeat (3) step();
        retire = 1'b0;
        exp_rd("minstret_3", 12'hB02, 32'd3);
        step(); step();
        exp_rd("minstret_hold", 12'hB02, 32'd3);
        exp_rd("minstret_hi", 12'hB82, 32'd0);
        step();
        force dut.mcycle_reg = 64'h0000_0000_FFFF_FFFD;
        #1;
        release dut.mcycle_reg;
        exp_rd("mcycle_preload", 12'hB00, 32'hFFFF_FFFD);
        exp_rd("mcycleh_preload", 12'hB80, 32'h0);
        step();
        exp_rd("mcycle_inc1", 12'hB00, 32'hFFFF_FFFE);
        step();
        exp_rd("mcycle_inc2", 12'hB00, 32'hFFFF_FFFF);
        step();
        exp_rd("mcycle_wrap", 12'hB00, 32'h0);
        exp_rd("mcycleh_carry", 12'hB80, 32'h1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_reset_sleep();
        exp_t        e;
        logic [31:0] o;
        step();
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        #1;
        exp_val("rs_sleeping", 32'h1, {31'b0, wfi_stall});
        rst = 1'b1;
        #1;
        exp_val("rs_stall_cleared", 32'h0, {31'b0, wfi_stall});
        exp_rd("rs_mie",     12'h304, 32'h0);
        exp_rd("rs_mtvec",   12'h305, 32'h0001_0000);
        exp_rd("rs_mstatus", 12'h300, 32'h1800);
        step();
        rst = 1'b0;
        step();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_rs_rc();
        test_trap();
        test_mret();
        test_back_to_back();
        test_wfi();
        test_counters();
        test_reset_sleep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
